gen3_rx_frame_packer: RTL

//  Consumes the per-byte classification from the Gen3 byte checker (type code + data byte), drops

---
 rtl/gen3_rx_pkg.sv | 29 ++
 rtl/gen3_rx_lane_packer.sv | 86 ++++++++
 rtl/gen3_rx_frame_packer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/gen3_rx_pkg.sv
// rtl/gen3_rx_pkg.sv - Gen3 receive byte-type codes, packer FSM states and byte-enable helper.
package gen3_rx_pkg;

    localparam logic [5:0] T_NONE       = 6'b000000;
    localparam logic [5:0] T_DATA       = 6'b100000;
    localparam logic [5:0] T_TLP_START  = 6'b010000;
    localparam logic [5:0] T_TLP_END    = 6'b001000;
    localparam logic [5:0] T_DLLP_END   = 6'b000100;
    localparam logic [5:0] T_DLLP_START = 6'b000010;
    localparam logic [5:0] T_TLP_EDB    = 6'b000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TLP  = 2'd1,
        ST_DLLP = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    // Lane count 0 stands for a completed word, so it maps to all four lanes.
    function automatic logic [3:0] be_mask(input logic [1:0] lanes);
        case (lanes)
            2'd1:    be_mask = 4'h1;
            2'd2:    be_mask = 4'h3;
            2'd3:    be_mask = 4'h7;
            default: be_mask = 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/gen3_rx_lane_packer.sv
// rtl/gen3_rx_lane_packer.sv - Packs payload bytes into 32-bit beats; holds a full word until the
// next byte or the frame close decides its EOP.
module gen3_rx_lane_packer
    import gen3_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic [7:0]  data,
    input  logic        close,
    input  logic        close_abort,
    input  logic        frame_dllp,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [3:0]  out_be,
    output logic        out_sop,
    output logic        out_eop,
    output logic        out_dllp,
    output logic        out_abort
);

    logic [31:0] acc;
    logic [1:0]  idx;
    logic        full;
    logic        sop_pend;
    logic        pending;

    assign pending = full | (idx != 2'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            idx       <= '0;
            full      <= 1'b0;
            sop_pend  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_be    <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_dllp  <= 1'b0;
            out_abort <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_be    <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_dllp  <= 1'b0;
            out_abort <= 1'b0;
            if (close) begin
                // Unused upper lanes are always zero because acc is cleared per word/frame.
                if (pending) begin
                    out_valid <= 1'b1;
                    out_data  <= acc;
                    out_be    <= be_mask(idx);
                    out_sop   <= sop_pend;
                    out_eop   <= 1'b1;
                    out_dllp  <= frame_dllp;
                    out_abort <= close_abort;
                end
                acc      <= '0;
                idx      <= '0;
                full     <= 1'b0;
                sop_pend <= 1'b1;
            end else if (wr) begin
                if (full) begin
                    out_valid <= 1'b1;
                    out_data  <= acc;
                    out_be    <= 4'hF;
                    out_sop   <= sop_pend;
                    out_dllp  <= frame_dllp;
                    sop_pend  <= 1'b0;
                    acc       <= {24'h000000, data};
                    idx       <= 2'd1;
                    full      <= 1'b0;
                end else begin
                    acc[{idx, 3'b000} +: 8] <= data;
                    idx                     <= idx + 2'd1;
                    full                    <= (idx == 2'd3);
                end
            end
        end
    end

endmodule

// File: rtl/gen3_rx_frame_packer.sv
// rtl/gen3_rx_frame_packer.sv - Gen3 RX frame FSM: strips delimiters, packs payload, flags aborts.
// Optional frame statistics counters enabled by RX_FRAME_STATS_EN.
module gen3_rx_frame_packer
    import gen3_rx_pkg::*;
#(
    parameter int MAX_FRAME_BYTES = 4096,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             byte_valid,
    input  logic [7:0]       data_in,
    input  logic [5:0]       type_in,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic [3:0]       out_be,
    output logic             out_sop,
    output logic             out_eop,
    output logic             out_dllp,
    output logic             out_abort,
    output logic             err_proto,
    output logic [CNT_W-1:0] stat_tlp,
    output logic [CNT_W-1:0] stat_dllp,
    output logic [CNT_W-1:0] stat_abort
);

    localparam logic [12:0] MAX_CNT = 13'(MAX_FRAME_BYTES);

    state_t      state_q, state_d;
    logic [12:0] pay_cnt;
    logic        is_data, is_tlp_start, is_dllp_start, is_start, is_edb, is_end;
    logic        wr, close, close_abort, err_d, cnt_clr, cnt_inc;

    assign is_data       = byte_valid && (type_in == T_DATA);
    assign is_tlp_start  = byte_valid && (type_in == T_TLP_START);
    assign is_dllp_start = byte_valid && (type_in == T_DLLP_START);
    assign is_start      = is_tlp_start | is_dllp_start;
    assign is_edb        = byte_valid && (type_in == T_TLP_EDB);
    assign is_end        = is_edb | (byte_valid && ((type_in == T_TLP_END) || (type_in == T_DLLP_END)));

    always_comb begin
        state_d     = state_q;
        wr          = 1'b0;
        close       = 1'b0;
        close_abort = 1'b0;
        err_d       = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_start) begin
                    state_d = is_tlp_start ? ST_TLP : ST_DLLP;
                    cnt_clr = 1'b1;
                end else if (is_data || is_end) begin
                    err_d = 1'b1;
                end
            end
            ST_TLP, ST_DLLP: begin
                if (is_start) begin
                    // Restart: the old frame closes aborted while the new one opens.
                    close       = 1'b1;
                    close_abort = 1'b1;
                    err_d       = 1'b1;
                    cnt_clr     = 1'b1;
                    state_d     = is_tlp_start ? ST_TLP : ST_DLLP;
                end else if (is_end) begin
                    close       = 1'b1;
                    close_abort = is_edb;
                    err_d       = (pay_cnt == 13'd0);
                    state_d     = ST_IDLE;
                end else if (is_data) begin
                    if (pay_cnt == MAX_CNT) begin
                        // This byte would be number MAX+1: flush what is held and discard the rest.
                        close       = 1'b1;
                        close_abort = 1'b1;
                        state_d     = ST_DROP;
                    end else begin
                        wr      = 1'b1;
                        cnt_inc = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (is_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pay_cnt   <= '0;
            err_proto <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_proto <= err_d;
            if (cnt_clr) begin
                pay_cnt <= '0;
            end else if (cnt_inc && (pay_cnt != '1)) begin
                pay_cnt <= pay_cnt + 13'd1;
            end
        end
    end

    gen3_rx_lane_packer u_lane_packer (
        .clk         (clk),
        .rst         (rst),
        .wr          (wr),
        .data        (data_in),
        .close       (close),
        .close_abort (close_abort),
        .frame_dllp  (state_q == ST_DLLP),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_be      (out_be),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_dllp    (out_dllp),
        .out_abort   (out_abort)
    );

`ifdef RX_FRAME_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_tlp   <= '0;
            stat_dllp  <= '0;
            stat_abort <= '0;
        end else if (out_valid && out_eop) begin
            if (out_abort) begin
                if (stat_abort != '1) stat_abort <= stat_abort + 1'b1;
            end else if (out_dllp) begin
                if (stat_dllp != '1) stat_dllp <= stat_dllp + 1'b1;
            end else begin
                if (stat_tlp != '1) stat_tlp <= stat_tlp + 1'b1;
            end
        end
    end
`else
    assign stat_tlp   = '0;
    assign stat_dllp  = '0;
    assign stat_abort = '0;
`endif

endmodule
